minimal_mem_initiator: RTL and testbench

//  Synthesizable initiator for the minimal-memory interface (Mout_oe/we/addr/Wdata/data_ram_size out;
//  M_Rdata_ram/M_DataRdy in). It is the counterpart of the simulation memory responder.
//  It accepts read/write requests on a valid/ready channel, buffers them and issues them one at a time.
//  It returns read data and write acks on a response channel. It sits between on-chip glue logic and an external/shared RAM.

---
 rtl/mmi_pkg.sv | 24 ++
 rtl/mmi_req_fifo.sv | 40 ++++
 rtl/minimal_mem_initiator.sv | 142 ++++++++++++++
 tb/tb_minimal_mem_initiator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmi_pkg.sv
// Shared types for the minimal-memory initiator: FSM states, request record, size mask helper.
package mmi_pkg;
  localparam int MMI_ADDR_W = 7;
  localparam int MMI_DATA_W = 8;
  localparam int MMI_SIZE_W = $clog2(MMI_DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [MMI_ADDR_W-1:0] addr;
    logic [MMI_DATA_W-1:0] wdata;
    logic [MMI_SIZE_W-1:0] size;
  } req_t;

  // Low `size` bits set; callers pass an already-normalised size (1..DATA_W).
  function automatic logic [MMI_DATA_W-1:0] size_mask(input logic [MMI_SIZE_W-1:0] size);
    logic [MMI_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MMI_DATA_W; i++)
      if (i < int'(size)) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/mmi_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module mmi_req_fifo
  import mmi_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = req_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wr_q, rd_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/minimal_mem_initiator.sv
// Initiator for the minimal-memory bus: buffers requests, issues one access at a time, returns responses.
// Optional watchdog on stuck accesses is built when MMI_TIMEOUT_EN is defined.
module minimal_mem_initiator
  import mmi_pkg::*;
#(
  parameter int  ADDR_W      = MMI_ADDR_W,
  parameter int  DATA_W      = MMI_DATA_W,
  parameter int  FIFO_DEPTH  = 2,
  parameter int  TIMEOUT_CYC = 64,
  localparam int SIZE_W      = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);
  localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(DATA_W);

  state_t            state_q, state_d;
  req_t              fifo_din, fifo_dout, cmd_q;
  logic              fifo_full, fifo_empty, push, pop, timeout;
  logic [SIZE_W-1:0] size_n;
  logic [DATA_W-1:0] mask_in, mask_cmd, rdata_q;

  // Size and write data are normalised on the way in so the bus sees clean values.
  assign size_n   = (req_size == '0 || req_size > FULL_SIZE) ? FULL_SIZE : req_size;
  assign mask_in  = size_mask(size_n);
  assign mask_cmd = size_mask(cmd_q.size);

  always_comb begin
    fifo_din       = '0;
    fifo_din.we    = req_we;
    fifo_din.addr  = req_addr;
    fifo_din.wdata = req_we ? (req_wdata & mask_in) : '0;
    fifo_din.size  = size_n;
  end

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  mmi_req_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    pop                = 1'b0;
    rsp_valid          = 1'b0;
    Mout_oe_ram        = 1'b0;
    Mout_we_ram        = 1'b0;
    Mout_addr_ram      = '0;
    Mout_Wdata_ram     = '0;
    Mout_data_ram_size = '0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        Mout_oe_ram        = !cmd_q.we;
        Mout_we_ram        = cmd_q.we;
        Mout_addr_ram      = cmd_q.addr;
        Mout_Wdata_ram     = cmd_q.wdata;
        Mout_data_ram_size = cmd_q.size;
        if (M_DataRdy || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) cmd_q <= fifo_dout;
      if (state_q == ISSUE) begin
        if (M_DataRdy)    rdata_q <= cmd_q.we ? '0 : (M_Rdata_ram & mask_cmd);
        else if (timeout) rdata_q <= '0;
      end
    end
  end

  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;

`ifdef MMI_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // Held at zero outside ISSUE, so every access starts counting from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 wd_q <= '0;
    else if (state_q != ISSUE) wd_q <= '0;
    else                       wd_q <= wd_q + WD_W'(1);
  end

  assign timeout = (state_q == ISSUE) && !M_DataRdy && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 err_q <= 1'b0;
    else if (state_q == ISSUE) err_q <= timeout;
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_minimal_mem_initiator.sv
// Directed bench for minimal_mem_initiator with a delay-2 read / delay-1 write responder model.
`timescale 1ns/1ps
module tb_minimal_mem_initiator;
  localparam int AW = 7, DW = 8, SW = 4;

  logic          clock = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_size = '0;
  logic          req_ready, rsp_valid, rsp_err, oe, we, drdy;
  logic [DW-1:0] rsp_rdata, mwdata, mrdata;
  logic [AW-1:0] maddr;
  logic [SW-1:0] msize;

  int            checks = 0, failures = 0;
  logic [7:0]    mem [128];
  logic [7:0]    ref_mem [128];
  logic [7:0]    expq [$];
  int            busy;
  bit            resp_en = 1'b1;
  logic          done_prev;

  always #5 clock = ~clock;

  minimal_mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2), .TIMEOUT_CYC(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(maddr), .Mout_Wdata_ram(mwdata),
    .Mout_data_ram_size(msize), .M_Rdata_ram(mrdata), .M_DataRdy(drdy)
  );

  function automatic logic [7:0] tmask(input int s);
    int e;
    e = (s == 0 || s > 8) ? 8 : s;
    return (e == 8) ? 8'hFF : 8'((1 << e) - 1);
  endfunction

  // Responder: read completes in its 2nd active cycle, write in its 1st; size-merged writes.
  always @(posedge clock or posedge reset) begin
    if (reset) busy <= 0;
    else begin
      busy <= (oe || we) ? busy + 1 : 0;
      if (we && drdy) mem[maddr] <= (mem[maddr] & ~tmask(int'(msize))) | mwdata;
    end
  end
  assign drdy   = resp_en && ((oe && busy == 1) || (we && busy == 0));
  assign mrdata = mem[maddr];

  always @(posedge clock or posedge reset) begin
    if (reset) done_prev <= 1'b0;
    else       done_prev <= (oe || we) && drdy;
  end

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert (!(oe && we)) else begin
        failures++; $error("FAIL oe_we_overlap observed=1 expected=0");
      end
      if (done_prev) begin
        checks++;
        assert (!(oe || we)) else begin
          failures++; $error("FAIL idle_gap observed=%b expected=0", oe || we);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++; $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n;
    n = 0;
    req_we = w; req_addr = a; req_wdata = d; req_size = s; req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) begin
      checks++; failures++; $error("FAIL send_timeout observed=%0d expected<200", n);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // lat counts posedges from the accepting one up to the one that raised rsp_valid.
  task automatic wait_rsp(output int lat, output logic [SW-1:0] bsize, output logic [DW-1:0] bwdata);
    lat = 1; bsize = '0; bwdata = '0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clock); lat++;
      if (oe || we) begin bsize = msize; bwdata = mwdata; end
    end
    if (!rsp_valid) begin
      checks++; failures++; $error("FAIL rsp_timeout observed=0 expected=1");
    end
  endtask

  int            lat, seen;
  logic [SW-1:0] bs;
  logic [DW-1:0] bw;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'hFF;
    mem[7'h20] = 8'h5A;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_bus", {oe, we, maddr, mwdata, msize}, 0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);

    // 1: write then read back, with latencies
    send(1'b1, 7'h05, 8'hA5, 4'd8);
    wait_rsp(lat, bs, bw);
    chk("t1_wr_lat", lat, 3);
    chk("t1_wr_rdata", rsp_rdata, 0);
    chk("t1_wr_err", rsp_err, 0);
    chk("t1_wr_bus_wdata", bw, 8'hA5);
    send(1'b0, 7'h05, 8'h00, 4'd8);
    wait_rsp(lat, bs, bw);
    chk("t1_rd_lat", lat, 4);
    chk("t1_rd_rdata", rsp_rdata, 8'hA5);

    // 2: size masking and size normalisation
    send(1'b0, 7'h10, 8'h00, 4'd4);
    wait_rsp(lat, bs, bw);
    chk("t2_rd4_rdata", rsp_rdata, 8'h0F);
    chk("t2_rd4_size", bs, 4);
    send(1'b1, 7'h10, 8'h3C, 4'd4);
    wait_rsp(lat, bs, bw);
    chk("t2_wr4_wdata", bw, 8'h0C);
    chk("t2_wr4_mem", mem[7'h10], 8'hFC);
    send(1'b0, 7'h10, 8'h00, 4'd0);
    wait_rsp(lat, bs, bw);
    chk("t2_size0_rdata", rsp_rdata, 8'hFC);
    chk("t2_size0_bus", bs, 8);
    send(1'b0, 7'h10, 8'h00, 4'd12);
    wait_rsp(lat, bs, bw);
    chk("t2_size12_rdata", rsp_rdata, 8'hFC);
    chk("t2_size12_bus", bs, 8);
    send(1'b0, 7'h10, 8'h00, 4'd3);
    wait_rsp(lat, bs, bw);
    chk("t2_rd3_rdata", rsp_rdata, 8'h04);
    @(negedge clock);

    // 3: backpressure with three queued reads
    rsp_ready = 1'b0;
    send(1'b0, 7'h05, 8'h00, 4'd8);
    send(1'b0, 7'h10, 8'h00, 4'd8);
    send(1'b0, 7'h20, 8'h00, 4'd8);
    chk("t3_full_ready", req_ready, 0);
    repeat (4) @(negedge clock);
    chk("t3_hold_valid", rsp_valid, 1);
    chk("t3_hold_bus", {oe, we}, 0);
    chk("t3_hold_ready", req_ready, 0);
    rsp_ready = 1'b1;
    wait_rsp(lat, bs, bw);
    chk("t3_rsp0", rsp_rdata, 8'hA5);
    @(negedge clock);
    wait_rsp(lat, bs, bw);
    chk("t3_rsp1", rsp_rdata, 8'hFC);
    @(negedge clock);
    wait_rsp(lat, bs, bw);
    chk("t3_rsp2", rsp_rdata, 8'h5A);
    @(negedge clock);
    chk("t3_drained_valid", rsp_valid, 0);
    chk("t3_drained_ready", req_ready, 1);

    // 4: reset in the middle of a read with another request queued
    rsp_ready = 1'b0;
    send(1'b0, 7'h05, 8'h00, 4'd8);
    send(1'b0, 7'h10, 8'h00, 4'd8);
    chk("t4_pre_oe", oe, 1);
    reset = 1'b1;
    #1;
    chk("t4_async_bus", {oe, we, maddr, msize}, 0);
    chk("t4_async_valid", rsp_valid, 0);
    chk("t4_async_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (rsp_valid || oe || we) seen++;
    end
    chk("t4_quiet_after", seen, 0);

`ifdef MMI_TIMEOUT_EN
    // 5: responder never answers; abort 64 cycles after ISSUE entry
    resp_en = 1'b0;
    send(1'b0, 7'h05, 8'h00, 4'd8);
    wait_rsp(lat, bs, bw);
    chk("t5_timeout_lat", lat - 2, 64);
    chk("t5_err", rsp_err, 1);
    chk("t5_rdata", rsp_rdata, 0);
    chk("t5_oe", oe, 0);
    resp_en = 1'b1;
    @(negedge clock);
`endif

    // 6: random traffic with random response stalls against a reference memory
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    fork
      begin
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        logic [SW-1:0] s;
        for (int i = 0; i < 300; i++) begin
          w = 1'($urandom_range(0, 1));
          a = 7'($urandom_range(0, 15));
          d = 8'($urandom_range(0, 255));
          s = 4'($urandom_range(0, 15));
          m = tmask(int'(s));
          send(w, a, d, s);
          if (w) begin
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            expq.push_back(8'h00);
          end else expq.push_back(ref_mem[a] & m);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      begin
        int got, idle;
        got = 0; idle = 0;
        while (got < 300 && idle < 2000) begin
          @(negedge clock);
          rsp_ready = ($urandom_range(0, 3) != 0);
          if (rsp_valid && rsp_ready) begin
            chk("t6_rdata", rsp_rdata, expq.pop_front());
            chk("t6_err", rsp_err, 0);
            got++; idle = 0;
          end else idle++;
        end
        if (got < 300) begin
          checks++; failures++; $error("FAIL t6_count observed=%0d expected=300", got);
        end
      end
    join
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
